// File: rtl/demux2_buf.sv
// 1-to-2 stream demultiplexer, each destination behind its own 2-entry FIFO.
// Latency: 1 cycle from accept to outN_valid; outputs are registered.
// Backpressure: in_ready follows only the selected FIFO; the other one stalls independently.
// Optional DEMUX2_BUF_STATS_EN adds free-running per-output accept counters cnt0/cnt1.

module demux2_buf_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rptr;
    logic             wptr;
    logic             pop;

    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rptr];
    assign pop        = head_valid & pop_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            // Entries are left stale; count=0 hides them.
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

module demux2_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX2_BUF_STATS_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    logic       sel1;
    logic       run;
    logic       accept;
    logic       push0;
    logic       push1;
    logic [1:0] count0;
    logic [1:0] count1;

    // X/Z select falls through to out0, like the mux2 select.
    assign sel1 = (in_sel === 1'b1);

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) run <= 1'b0;
        else         run <= 1'b1;
    end

    assign in_ready = run & (sel1 ? ((count1 != 2'd2) | out1_ready)
                                  : ((count0 != 2'd2) | out0_ready));
    assign accept   = in_valid & in_ready;
    assign push0    = accept & ~sel1 & ~flush;
    assign push1    = accept &  sel1 & ~flush;

    demux2_buf_fifo #(.WIDTH(WIDTH)) u_fifo0 (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .push       (push0),
        .push_data  (in_data),
        .pop_ready  (out0_ready),
        .head_valid (out0_valid),
        .head_data  (out0_data),
        .count      (count0)
    );

    demux2_buf_fifo #(.WIDTH(WIDTH)) u_fifo1 (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .push       (push1),
        .push_data  (in_data),
        .pop_ready  (out1_ready),
        .head_valid (out1_valid),
        .head_data  (out1_data),
        .count      (count1)
    );

`ifdef DEMUX2_BUF_STATS_EN
    // Counts every handshake, including ones discarded by flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else begin
            if (accept && !sel1) cnt0 <= cnt0 + 16'd1;
            if (accept &&  sel1) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux2_buf.sv
// Directed table-driven bench for demux2_buf plus hand-written corner-case sequences.
module tb_demux2_buf;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
`ifdef DEMUX2_BUF_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    demux2_buf #(.WIDTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX2_BUF_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       r0;
        logic       r1;
        logic       er;
        logic       ev0;
        logic [7:0] ed0;
        logic       ev1;
        logic [7:0] ed1;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic r0, logic r1,
                                logic er, logic ev0, logic [7:0] ed0,
                                logic ev1, logic [7:0] ed1);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1;
        t.er = er; t.ev0 = ev0; t.ed0 = ed0; t.ev1 = ev1; t.ed1 = ed1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1, input logic fl);
        in_valid = v; in_sel = s; in_data = d;
        out0_ready = r0; out1_ready = r1; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pexp [10];

    initial begin
        resetn = 1'b0;
        drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);

        vq.push_back(mk(1,0,8'hA5,1,1, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(1,1,8'h3C,1,1, 1, 1,8'hA5, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,1,1, 1, 0,8'h00, 1,8'h3C));
        vq.push_back(mk(0,0,8'h00,1,1, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(1,1,8'h11,1,0, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(1,1,8'h22,1,0, 1, 0,8'h00, 1,8'h11));
        vq.push_back(mk(1,1,8'h33,1,0, 0, 0,8'h00, 1,8'h11));
        vq.push_back(mk(1,1,8'h33,1,1, 1, 0,8'h00, 1,8'h11));
        vq.push_back(mk(0,0,8'h00,1,1, 1, 0,8'h00, 1,8'h22));
        vq.push_back(mk(0,0,8'h00,1,1, 1, 0,8'h00, 1,8'h33));
        vq.push_back(mk(1,0,8'h40,0,1, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(1,0,8'h41,0,1, 1, 1,8'h40, 0,8'h00));
        vq.push_back(mk(1,1,8'h50,0,1, 1, 1,8'h40, 0,8'h00));
        vq.push_back(mk(1,1,8'h51,0,1, 1, 1,8'h40, 1,8'h50));
        vq.push_back(mk(1,1,8'h52,0,1, 1, 1,8'h40, 1,8'h51));
        vq.push_back(mk(1,0,8'h42,0,1, 0, 1,8'h40, 1,8'h52));
        vq.push_back(mk(1,0,8'h42,1,1, 1, 1,8'h40, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,1,1, 1, 1,8'h41, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,1,1, 1, 1,8'h42, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,1,1, 1, 0,8'h00, 0,8'h00));

        // Reset state
        #12;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_out0_valid", {15'd0, out0_valid}, 16'd0);
        chk("rst_out1_valid", {15'd0, out1_valid}, 16'd0);
        chk("rst_out0_data", {8'd0, out0_data}, 16'd0);
        chk("rst_out1_data", {8'd0, out1_data}, 16'd0);
        #1 resetn = 1'b1;
        #1 chk("rdy_before_edge", {15'd0, in_ready}, 16'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        next_cycle();
        chk("rdy_after_edge", {15'd0, in_ready}, 16'd1);

        // Table: route, backpressure fill, independent stall
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].v, vq[i].s, vq[i].d, vq[i].r0, vq[i].r1, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), {15'd0, in_ready}, {15'd0, vq[i].er});
            chk($sformatf("v%0d_out0_valid", i), {15'd0, out0_valid}, {15'd0, vq[i].ev0});
            chk($sformatf("v%0d_out1_valid", i), {15'd0, out1_valid}, {15'd0, vq[i].ev1});
            if (vq[i].ev0) chk($sformatf("v%0d_out0_data", i), {8'd0, out0_data}, {8'd0, vq[i].ed0});
            if (vq[i].ev1) chk($sformatf("v%0d_out1_data", i), {8'd0, out1_data}, {8'd0, vq[i].ed1});
            next_cycle();
        end

        // Full pass-through: out0 held at count 2 while streaming 8 words
        drive(1'b1, 1'b0, 8'hE0, 1'b0, 1'b1, 1'b0); next_cycle();
        drive(1'b1, 1'b0, 8'hE1, 1'b0, 1'b1, 1'b0); next_cycle();
        pexp[0] = 8'hE0; pexp[1] = 8'hE1;
        for (int i = 0; i < 8; i++) pexp[i+2] = 8'hF0 + 8'(i);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 8'hF0 + 8'(i), 1'b1, 1'b1, 1'b0);
            else       drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            if (i < 8) chk($sformatf("pt%0d_in_ready", i), {15'd0, in_ready}, 16'd1);
            chk($sformatf("pt%0d_out0_valid", i), {15'd0, out0_valid}, 16'd1);
            chk($sformatf("pt%0d_out0_data", i), {8'd0, out0_data}, {8'd0, pexp[i]});
            next_cycle();
        end
        @(negedge clk);
        chk("pt_drained", {15'd0, out0_valid}, 16'd0);
        next_cycle();

        // X select routes to out0
        drive(1'b1, 1'bx, 8'h5A, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("xsel_in_ready", {15'd0, in_ready}, 16'd1);
        next_cycle();
        drive(1'b1, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("xsel_out0_valid", {15'd0, out0_valid}, 16'd1);
        chk("xsel_out0_data", {8'd0, out0_data}, 16'h005A);
        chk("xsel_out1_valid", {15'd0, out1_valid}, 16'd0);
        next_cycle();
        drive(1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 1'b1, 8'h72, 1'b0, 1'b0, 1'b0); next_cycle();

        // Flush with a concurrent accept
        drive(1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_in_ready", {15'd0, in_ready}, 16'd1);
        chk("flush_pre_out1_valid", {15'd0, out1_valid}, 16'd1);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_out0_valid", {15'd0, out0_valid}, 16'd0);
        chk("flush_out1_valid", {15'd0, out1_valid}, 16'd0);
        next_cycle();
        drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_still_empty", {15'd0, out0_valid}, 16'd0);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_flush_valid", {15'd0, out0_valid}, 16'd1);
        chk("post_flush_data", {8'd0, out0_data}, 16'h0077);
        next_cycle();

        // Async reset with both FIFOs non-empty
        drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0); next_cycle();
        drive(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_arst_valids", {14'd0, out0_valid, out1_valid}, 16'd3);
        #1 resetn = 1'b0;
        #1;
        chk("arst_out0_valid", {15'd0, out0_valid}, 16'd0);
        chk("arst_out1_valid", {15'd0, out1_valid}, 16'd0);
        chk("arst_out0_data", {8'd0, out0_data}, 16'd0);
        chk("arst_in_ready", {15'd0, in_ready}, 16'd0);
        #1 resetn = 1'b1;
        next_cycle();
        chk("arst_release_rdy", {15'd0, in_ready}, 16'd1);
        chk("arst_release_valid", {14'd0, out0_valid, out1_valid}, 16'd0);

`ifdef DEMUX2_BUF_STATS_EN
        resetn = 1'b0;
        #1;
        chk("stats_rst_cnt0", cnt0, 16'd0);
        resetn = 1'b1;
        next_cycle();
        drive(1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 65536; i++) next_cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        chk("stats_cnt0_wrap", cnt0, 16'd0);
        chk("stats_cnt1_idle", cnt1, 16'd0);
        drive(1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        chk("stats_cnt1_one", cnt1, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
